systemx_arbiter: RTL and testbench

Round-robin arbiter and select sequencer for the shared three-source `systemx` selector. It accepts requests from the three sources behind inputs B1, B2 and B3, and grants exactly one at a time. It drives the 2-bit select code the selector decodes: 00 = none/output 0, 01 = B1, 10 = B2, 11 = B3. A one-cycle break-before-make gap separates owners. A hold limit prevents one source from starving the others.

---
 rtl/systemx_arbiter_if.sv | 13 +
 rtl/systemx_arbiter.sv | 111 +++++++++++
 tb/tb_systemx_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/systemx_arbiter_if.sv
// Request/grant bundle between the three systemx sources and the select arbiter.
// Sources drive req/done; the arbiter drives the registered select and status lines.
interface systemx_arbiter_if;
    logic [2:0] req;
    logic       done;
    logic [1:0] sel;
    logic [2:0] gnt;
    logic       busy;
    logic       timeout;

    modport master (output req, done, input sel, gnt, busy, timeout);
    modport slave  (input req, done, output sel, gnt, busy, timeout);
endinterface

// File: rtl/systemx_arbiter.sv
// Round-robin arbiter driving the systemx 2-bit select code, with a one-cycle
// break-before-make gap between owners and a hold limit under competition.
module systemx_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst,
    systemx_arbiter_if.slave   arb_if,
    output logic [1:0]         dbg_state_o
);
    // Handshake: req is a level held by each source while it wants the selector;
    // done is a single-cycle release from the current owner, only honoured in GRANT.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t     state_q;
    logic [1:0] owner_q;
    logic [1:0] last_q;
    logic [7:0] hold_q;
    logic [1:0] sel_q;
    logic [2:0] gnt_q;
    logic       busy_q;
    logic       timeout_q;

    logic [1:0] win_idx;
    logic       any_req;
    logic       owner_req;
    logic       others_req;
    logic       at_limit;

    // Search last+1, last+2, last (mod 3); scanning in reverse lets the first hit win.
    always_comb begin
        logic [2:0] pos;
        win_idx = last_q;
        for (int k = 3; k >= 1; k--) begin
            pos = {1'b0, last_q} + 3'(k);
            if (pos >= 3'd3) pos = pos - 3'd3;
            if (arb_if.req[pos[1:0]]) win_idx = pos[1:0];
        end
    end

    always_comb begin
        any_req    = |arb_if.req;
        owner_req  = arb_if.req[owner_q];
        others_req = |(arb_if.req & ~(3'b001 << owner_q));
        at_limit   = (hold_q == 8'(MAX_HOLD));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= 2'd0;
            last_q    <= 2'd2;
            hold_q    <= 8'd0;
            sel_q     <= 2'b00;
            gnt_q     <= 3'b000;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE, GAP: begin
                    if (any_req) begin
                        state_q <= GRANT;
                        owner_q <= win_idx;
                        last_q  <= win_idx;
                        hold_q  <= 8'd1;
                        sel_q   <= win_idx + 2'd1;
                        gnt_q   <= 3'b001 << win_idx;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        hold_q  <= 8'd0;
                        sel_q   <= 2'b00;
                        gnt_q   <= 3'b000;
                        busy_q  <= 1'b0;
                    end
                end
                GRANT: begin
                    if (arb_if.done || !owner_req || (at_limit && others_req)) begin
                        state_q   <= GAP;
                        hold_q    <= 8'd0;
                        sel_q     <= 2'b00;
                        gnt_q     <= 3'b000;
                        busy_q    <= 1'b1;
                        timeout_q <= !arb_if.done && owner_req;
                    end else if (!at_limit) begin
                        hold_q <= hold_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    sel_q   <= 2'b00;
                    gnt_q   <= 3'b000;
                    busy_q  <= 1'b0;
                    hold_q  <= 8'd0;
                end
            endcase
        end
    end

    assign arb_if.sel     = sel_q;
    assign arb_if.gnt     = gnt_q;
    assign arb_if.busy    = busy_q;
    assign arb_if.timeout = timeout_q;
    assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_systemx_arbiter.sv
// Directed and randomized checks of systemx_arbiter against a cycle-level
// behavioural model of owner, round-robin pointer and hold count.
module tb_systemx_arbiter;
    localparam int MAX_HOLD = 4;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;
    int         tests_run;
    int         tests_failed;

    systemx_arbiter_if arb_if ();

    systemx_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk         (clk),
        .rst         (rst),
        .arb_if      (arb_if),
        .dbg_state_o (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: m_own = -1 when nobody owns the selector.
    int m_own;
    int m_last;
    int m_held;
    bit m_gap;
    bit m_to;

    task automatic model_edge(input logic [2:0] r, input logic d, input logic rs);
        if (rs) begin
            m_own = -1; m_last = 2; m_held = 0; m_gap = 0; m_to = 0;
        end else if (m_own >= 0) begin
            m_to = 0;
            if (d || !r[m_own] || (m_held == MAX_HOLD && (r & ~(3'b001 << m_own)) != 3'b000)) begin
                m_to  = !d && r[m_own];
                m_own = -1;
                m_gap = 1;
                m_held = 0;
            end else if (m_held < MAX_HOLD) begin
                m_held++;
            end
        end else begin
            m_to = 0;
            m_gap = 0;
            for (int k = 1; k <= 3; k++) begin
                if (m_own < 0 && r[(m_last + k) % 3]) m_own = (m_last + k) % 3;
            end
            if (m_own >= 0) begin
                m_last = m_own;
                m_held = 1;
            end
        end
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic [1:0] e_sel;
        logic [2:0] e_gnt;
        e_sel = (m_own >= 0) ? 2'(m_own + 1) : 2'b00;
        e_gnt = (m_own >= 0) ? (3'b001 << m_own) : 3'b000;
        check("model_sel",     {2'b00, arb_if.sel},     {2'b00, e_sel});
        check("model_gnt",     {1'b0, arb_if.gnt},      {1'b0, e_gnt});
        check("model_busy",    {3'b000, arb_if.busy},   {3'b000, (m_own >= 0) || m_gap});
        check("model_timeout", {3'b000, arb_if.timeout}, {3'b000, m_to});
    endtask

    // One clock: drive inputs, clock the model with the same values, sample 1ns after.
    task automatic cyc(input logic [2:0] r, input logic d, input logic rs);
        arb_if.req  = r;
        arb_if.done = d;
        rst         = rs;
        @(posedge clk);
        model_edge(r, d, rs);
        #1;
        check_model();
    endtask

    task automatic expect_out(input string tag, input logic [1:0] s, input logic b, input logic t);
        check({tag, "_sel"},     {2'b00, arb_if.sel},      {2'b00, s});
        check({tag, "_busy"},    {3'b000, arb_if.busy},    {3'b000, b});
        check({tag, "_timeout"}, {3'b000, arb_if.timeout}, {3'b000, t});
    endtask

    initial begin
        logic [1:0] rr_seq [3];
        logic [2:0] r;
        tests_run = 0;
        tests_failed = 0;
        m_own = -1; m_last = 2; m_held = 0; m_gap = 0; m_to = 0;
        arb_if.req = 3'b000;
        arb_if.done = 1'b0;
        rst = 1'b1;
        #2;

        // Reset and single request
        cyc(3'b000, 0, 1);
        cyc(3'b000, 0, 1);
        cyc(3'b000, 0, 0);
        expect_out("reset_idle", 2'b00, 0, 0);
        check("reset_gnt", {1'b0, arb_if.gnt}, 4'h0);
        cyc(3'b001, 0, 0);
        expect_out("single_grant", 2'b01, 1, 0);
        check("single_gnt", {1'b0, arb_if.gnt}, 4'h1);
        cyc(3'b001, 1, 0);
        expect_out("single_gap", 2'b00, 1, 0);
        cyc(3'b000, 0, 0);
        expect_out("single_idle", 2'b00, 0, 0);

        // Simultaneous requests rotate B1, B2, B3, B1
        cyc(3'b000, 0, 1);
        rr_seq[0] = 2'b01; rr_seq[1] = 2'b10; rr_seq[2] = 2'b11;
        for (int i = 0; i < 3; i++) begin
            cyc(3'b111, 0, 0);
            expect_out("rr_grant", rr_seq[i], 1, 0);
            cyc(3'b111, 0, 0);
            cyc(3'b111, 1, 0);
            expect_out("rr_gap", 2'b00, 1, 0);
        end
        cyc(3'b111, 0, 0);
        expect_out("rr_wrap", 2'b01, 1, 0);

        // Hold limit: B2 owns, B3 waits
        cyc(3'b000, 0, 1);
        cyc(3'b010, 0, 0);
        expect_out("hold_c1", 2'b10, 1, 0);
        for (int i = 0; i < MAX_HOLD - 1; i++) begin
            cyc(3'b110, 0, 0);
            expect_out("hold_cn", 2'b10, 1, 0);
        end
        cyc(3'b110, 0, 0);
        expect_out("hold_gap", 2'b00, 1, 1);
        cyc(3'b110, 0, 0);
        expect_out("hold_next", 2'b11, 1, 0);

        // No competition keeps the grant indefinitely
        cyc(3'b000, 0, 1);
        for (int i = 0; i < 20; i++) begin
            cyc(3'b010, 0, 0);
            expect_out("solo", 2'b10, 1, 0);
        end

        // done coinciding with the hold limit wins, no timeout
        cyc(3'b000, 0, 1);
        cyc(3'b010, 0, 0);
        for (int i = 0; i < MAX_HOLD - 1; i++) cyc(3'b110, 0, 0);
        cyc(3'b110, 1, 0);
        expect_out("done_at_limit", 2'b00, 1, 0);

        // Owner withdraws its request
        cyc(3'b000, 0, 1);
        cyc(3'b100, 0, 0);
        cyc(3'b100, 0, 0);
        cyc(3'b000, 0, 0);
        expect_out("withdraw_gap", 2'b00, 1, 0);
        cyc(3'b000, 0, 0);
        expect_out("withdraw_idle", 2'b00, 0, 0);

        // Reset mid-grant drops the grant without a gap
        cyc(3'b100, 0, 0);
        expect_out("mid_grant", 2'b11, 1, 0);
        cyc(3'b111, 0, 1);
        expect_out("mid_reset", 2'b00, 0, 0);
        cyc(3'b111, 0, 0);
        expect_out("post_reset", 2'b01, 1, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            r = 3'($urandom_range(0, 7));
            cyc(r, ($urandom_range(0, 5) == 0), ($urandom_range(0, 60) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
